alu_decode_issue: RTL

Decode/issue stage that produces the ALU's command interface: accepts RV32I instruction words with a valid/ready handshake, decodes them into the 4-bit ALU operation code and operand pair, and registers the result toward execute through a 2-entry skid buffer. Sits between fetch/register-file read and the ALU, replacing the hard-wired single-cycle control path for the pipelined core.

---
 rtl/alu_pkg.sv | 76 +++++++
 rtl/imm_gen.sv | 24 ++
 rtl/alu_decode_issue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the decode/issue stage: ALU op codes, RV32I opcodes,
// immediate formats and the issued-command record.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_AND  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_LUI  = 4'b1010
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e         alu_op;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd_addr;
        logic            rd_wren;
        logic            mem_rden;
        logic            mem_wren;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
        logic [2:0]      funct3;
        logic [XLEN-1:0] pc;
    } issue_cmd_t;

    // Register/immediate ALU op from funct3; the alternate-encoding bit is
    // honoured for SUB only on register ops, for SRA on both.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3,
                                         input logic       sub_sel,
                                         input logic       sra_sel);
        alu_op_e op;
        case (f3)
            3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator for the I/S/B/U/J formats.
module imm_gen
    import alu_pkg::*;
(
    input  logic [31:0]     instr_i,
    input  logic [2:0]      fmt_i,
    output logic [XLEN-1:0] imm_o
);

    // Select and sign-extend the immediate field for the requested format
    always_comb begin
        case (fmt_i)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'h000};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/alu_decode_issue.sv
// RV32I decode/issue stage: decodes into an ALU command and issues it toward
// execute through a 2-entry skid buffer with a registered upstream ready.
module alu_decode_issue
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [4:0]  o_rs1Addr,
    output logic [4:0]  o_rs2Addr,
    input  logic [31:0] i_rs1Data,
    input  logic [31:0] i_rs2Data,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [3:0]  o_aluOp,
    output logic [31:0] o_operandA,
    output logic [31:0] o_operandB,
    output logic [31:0] o_storeData,
    output logic [4:0]  o_rdAddr,
    output logic        o_rdWren,
    output logic        o_memRden,
    output logic        o_memWren,
    output logic        o_isBranch,
    output logic        o_isJump,
    output logic        o_illegal,
    output logic [2:0]  o_funct3,
    output logic [31:0] o_pc
);

    logic [6:0]  opcode_s;
    imm_fmt_e    imm_fmt_s;
    logic [31:0] imm_s;
    issue_cmd_t  dec_s;
    logic        accept_s;
    logic        drain_s;

    issue_cmd_t  main_q, main_d;
    issue_cmd_t  skid_q, skid_d;
    logic        main_vld_q, main_vld_d;
    logic        skid_vld_q, skid_vld_d;

    assign opcode_s  = i_instr[6:0];
    assign o_rs1Addr = i_instr[19:15];
    assign o_rs2Addr = i_instr[24:20];

    // Immediate format implied by the opcode
    always_comb begin
        case (opcode_s)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_fmt_s = IMM_I;
            OPC_STORE:                      imm_fmt_s = IMM_S;
            OPC_BRANCH:                     imm_fmt_s = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_fmt_s = IMM_U;
            OPC_JAL:                        imm_fmt_s = IMM_J;
            default:                        imm_fmt_s = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (
        .instr_i (i_instr),
        .fmt_i   (imm_fmt_s),
        .imm_o   (imm_s)
    );

    // Decode the incoming word into an ALU command record
    always_comb begin
        dec_s         = {$bits(issue_cmd_t){1'b0}};
        dec_s.alu_op  = ALU_ADD;
        dec_s.rd_addr = i_instr[11:7];
        dec_s.funct3  = i_instr[14:12];
        dec_s.pc      = i_pc;
        case (opcode_s)
            OPC_OP: begin
                dec_s.alu_op    = f3_to_op(i_instr[14:12], i_instr[30], i_instr[30]);
                dec_s.operand_a = i_rs1Data;
                dec_s.operand_b = i_rs2Data;
                dec_s.rd_wren   = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_s.alu_op    = f3_to_op(i_instr[14:12], 1'b0, i_instr[30]);
                dec_s.operand_a = i_rs1Data;
                dec_s.operand_b = imm_s;
                dec_s.rd_wren   = 1'b1;
            end
            OPC_LOAD: begin
                dec_s.operand_a = i_rs1Data;
                dec_s.operand_b = imm_s;
                dec_s.mem_rden  = 1'b1;
                dec_s.rd_wren   = 1'b1;
            end
            OPC_STORE: begin
                dec_s.operand_a  = i_rs1Data;
                dec_s.operand_b  = imm_s;
                dec_s.store_data = i_rs2Data;
                dec_s.mem_wren   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_s.alu_op    = ALU_SUB;
                dec_s.operand_a = i_rs1Data;
                dec_s.operand_b = i_rs2Data;
                dec_s.is_branch = 1'b1;
            end
            OPC_LUI: begin
                dec_s.alu_op    = ALU_LUI;
                dec_s.operand_b = imm_s;
                dec_s.rd_wren   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_s.operand_a = i_pc;
                dec_s.operand_b = imm_s;
                dec_s.rd_wren   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // Execute computes the link value; the target is resolved elsewhere
                dec_s.operand_a = i_pc;
                dec_s.operand_b = 32'h0000_0004;
                dec_s.is_jump   = 1'b1;
                dec_s.rd_wren   = 1'b1;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
        dec_s.rd_wren = dec_s.rd_wren & (dec_s.rd_addr != 5'd0);
    end

    assign accept_s = i_valid & ~skid_vld_q;
    assign drain_s  = main_vld_q & i_ready;

    // Skid-buffer steering: main refills from skid first, then from upstream
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (i_flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain_s) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept_s) begin
                main_d     = dec_s;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept_s) begin
            skid_d     = dec_s;
            skid_vld_d = 1'b1;
        end else begin
            skid_vld_d = skid_vld_q;
        end
    end

    // Buffer state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            main_q     <= {$bits(issue_cmd_t){1'b0}};
            skid_q     <= {$bits(issue_cmd_t){1'b0}};
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign o_ready     = ~skid_vld_q;
    assign o_valid     = main_vld_q;
    assign o_aluOp     = main_q.alu_op;
    assign o_operandA  = main_q.operand_a;
    assign o_operandB  = main_q.operand_b;
    assign o_storeData = main_q.store_data;
    assign o_rdAddr    = main_q.rd_addr;
    assign o_rdWren    = main_q.rd_wren;
    assign o_memRden   = main_q.mem_rden;
    assign o_memWren   = main_q.mem_wren;
    assign o_isBranch  = main_q.is_branch;
    assign o_isJump    = main_q.is_jump;
    assign o_illegal   = main_q.illegal;
    assign o_funct3    = main_q.funct3;
    assign o_pc        = main_q.pc;

endmodule
